// File: rtl/lock_pkg.sv
// Shared state encoding, display codes and timer width for the lock controller.
package lock_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } lock_state_e;

    localparam int          TIMER_W        = 32;
    localparam logic [7:0]  DISP_UNLOCKED  = 8'h00;
    localparam logic [3:0]  DISP_LOCKED_HI = 4'hE;
    localparam logic [7:0]  DISP_LOCKOUT   = 8'hFF;

    function automatic logic [7:0] disp_code(input lock_state_e st, input logic [3:0] fails);
        logic [7:0] code;
        case (st)
            ST_UNLOCKED: code = DISP_UNLOCKED;
            ST_LOCKOUT:  code = DISP_LOCKOUT;
            default:     code = {DISP_LOCKED_HI, fails};
        endcase
        return code;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Shared up-counter for the timed states; done flags the cycle the count equals the terminal value.
module lock_timer
    import lock_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [TIMER_W-1:0] terminal,
    output logic               done
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = enable && (count_q == terminal);

endmodule

// File: rtl/lock_controller.sv
// Door lock FSM (LOCKED / UNLOCKED / LOCKOUT) with registered outputs.
// Optional alarm output is enabled by defining LOCK_ALARM_EN.
module lock_controller
    import lock_pkg::*;
#(
    parameter int unsigned UNLOCK_CYCLES  = 500_000_000,
    parameter int unsigned LOCKOUT_CYCLES = 1_000_000_000,
    parameter int unsigned MAX_FAILS      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       result_valid,
    input  logic       result_match,
    input  logic       lock_btn,
    output logic       door_unlock,
    output logic       lockout,
    output logic       alarm,
    output logic [3:0] fail_count,
    output logic [7:0] display_out
);

    localparam logic [TIMER_W-1:0] UNLOCK_TC  = TIMER_W'(UNLOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_TC = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]         MAX_FAILS_C = 4'(MAX_FAILS);

    lock_state_e state_q, state_d;
    logic [3:0]  fail_q, fail_d;
    logic [3:0]  fail_inc;
    logic        btn_prev_q;
    logic        btn_rise;
    logic        door_q, lockout_q;
    logic [7:0]  disp_q;
    logic        timer_clear;
    logic        timer_en;
    logic        timer_done;
    logic [TIMER_W-1:0] timer_tc;

    assign btn_rise = lock_btn & ~btn_prev_q;
    assign fail_inc = fail_q + 4'd1;
    assign timer_en = (state_q != ST_LOCKED);
    assign timer_tc = (state_q == ST_LOCKOUT) ? LOCKOUT_TC : UNLOCK_TC;

    lock_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (timer_clear),
        .enable   (timer_en),
        .terminal (timer_tc),
        .done     (timer_done)
    );

    // The timer is cleared on every cycle that leaves or restarts a timed state, and throughout LOCKED.
    always_comb begin
        state_d     = state_q;
        fail_d      = fail_q;
        timer_clear = 1'b0;
        case (state_q)
            ST_LOCKED: begin
                timer_clear = 1'b1;
                if (result_valid) begin
                    if (result_match) begin
                        state_d = ST_UNLOCKED;
                        fail_d  = 4'd0;
                    end else begin
                        fail_d = fail_inc;
                        if (fail_inc == MAX_FAILS_C) begin
                            state_d = ST_LOCKOUT;
                        end
                    end
                end
            end
            ST_UNLOCKED: begin
                if (timer_done || btn_rise) begin
                    state_d     = ST_LOCKED;
                    timer_clear = 1'b1;
                end else if (result_valid && result_match) begin
                    timer_clear = 1'b1;
                end
            end
            ST_LOCKOUT: begin
                if (timer_done) begin
                    state_d     = ST_LOCKED;
                    fail_d      = 4'd0;
                    timer_clear = 1'b1;
                end
            end
            default: begin
                state_d     = ST_LOCKED;
                fail_d      = 4'd0;
                timer_clear = 1'b1;
            end
        endcase
    end

`ifdef LOCK_ALARM_EN
    logic alarm_q;
    logic alarm_d;
    assign alarm_d = (state_d == ST_LOCKOUT) ||
                     ((state_q == ST_LOCKED) && result_valid && !result_match);
    assign alarm   = alarm_q;
`else
    assign alarm = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOCKED;
            fail_q     <= 4'd0;
            btn_prev_q <= 1'b0;
            door_q     <= 1'b0;
            lockout_q  <= 1'b0;
            disp_q     <= {DISP_LOCKED_HI, 4'd0};
`ifdef LOCK_ALARM_EN
            alarm_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fail_q     <= fail_d;
            btn_prev_q <= lock_btn;
            door_q     <= (state_d == ST_UNLOCKED);
            lockout_q  <= (state_d == ST_LOCKOUT);
            disp_q     <= disp_code(state_d, fail_d);
`ifdef LOCK_ALARM_EN
            alarm_q    <= alarm_d;
`endif
        end
    end

    assign door_unlock = door_q;
    assign lockout     = lockout_q;
    assign fail_count  = fail_q;
    assign display_out = disp_q;

endmodule
